// File: rtl/vga_spectrum_plotter.sv
// vga_spectrum_plotter
// ---------------------------------------------------------------------------
// Draws a bar-graph spectrum onto a 160x120, 6-bit-colour VGA pixel-plot port.
// FFT bin magnitudes are written into a pending bank at any time. Each frame
// starts by copying pending into an active bank. The frame then rasters every
// pixel, one per clock, and colours it from the active bank.
//
// Optional feature (define PEAK_HOLD_EN): per-bin decaying peak markers drawn
// in PEAK_COLOUR on top of the bars.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   bin_wr/bin_idx/bin_mag   write one magnitude into the pending bank
//   start                request one frame; only honoured while idle
//   busy                 high from the accepted start until the frame ends
//   done                 one-cycle pulse after the last pixel
//   plot                 pixel strobe; plot_x/plot_y/plot_colour are valid
//                        whenever plot=1 and hold otherwise
//   dbg_state            current FSM state (IDLE=0, SWAP=1, SCAN=2, DONE=3)
//
// Handshake: start is a request sampled only in IDLE. busy=1 means a request
// would be dropped. plot is a valid-only strobe, because the adapter has no
// back-pressure.
// ---------------------------------------------------------------------------
module vga_spectrum_plotter #(
    parameter int          NUM_BINS    = 32,
    parameter int          BAR_W       = 5,
    parameter int          MAG_W       = 8,
    parameter logic [5:0]  BAR_COLOUR  = 6'b001100,
    parameter logic [5:0]  BG_COLOUR   = 6'b000000,
    parameter logic [5:0]  PEAK_COLOUR = 6'b110000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        bin_wr,
    input  logic [$clog2(NUM_BINS)-1:0] bin_idx,
    input  logic [MAG_W-1:0]            bin_mag,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        plot,
    output logic [7:0]                  plot_x,
    output logic [6:0]                  plot_y,
    output logic [5:0]                  plot_colour,
    output logic [1:0]                  dbg_state
);

    localparam int         IDX_W      = $clog2(NUM_BINS);
    localparam logic [7:0] X_LAST     = 8'd159;
    localparam logic [6:0] Y_LAST     = 7'd119;
    localparam logic [7:0] PLOT_END_X = 8'(NUM_BINS * BAR_W);
    localparam logic [7:0] SUB_LAST   = 8'(BAR_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SWAP = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [MAG_W-1:0] pending_q [NUM_BINS];
    logic [MAG_W-1:0] pending_d [NUM_BINS];
    logic [MAG_W-1:0] active_q  [NUM_BINS];
    logic [MAG_W-1:0] active_d  [NUM_BINS];

    // Raster counters hold the coordinate of the next pixel to emit.
    // bin/sub replace an x / BAR_W divide.
    logic [7:0] cnt_x_q, cnt_x_d;
    logic [6:0] cnt_y_q, cnt_y_d;
    logic [7:0] bin_q, bin_d;
    logic [7:0] sub_q, sub_d;

    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [5:0] colour_q, colour_d;

    logic             wr_ok;
    logic [IDX_W-1:0] bin_sel;
    logic [MAG_W-1:0] mag_src;
    logic [6:0]       h_src;
    logic             in_range;
    logic             bar_hit;
    logic             peak_hit;
    logic [5:0]       pix_colour;
    logic             emit;

    // Height in rows: magnitudes of 120 or more fill the whole column.
    function automatic logic [6:0] clip_h(input logic [MAG_W-1:0] mag);
        logic [31:0] m;
        m = 32'(mag);
        return (m >= 32'd120) ? 7'd120 : m[6:0];
    endfunction

    assign wr_ok   = bin_wr && (32'(bin_idx) < 32'(NUM_BINS));
    assign bin_sel = bin_q[IDX_W-1:0];

`ifdef PEAK_HOLD_EN
    logic [6:0] peak_q [NUM_BINS];
    logic [6:0] peak_d [NUM_BINS];
    logic [6:0] peak_src;

    // The peak decays by one row per frame unless the new height is taller.
    always_comb begin
        peak_d = peak_q;
        if (state_q == S_SWAP) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                logic [6:0] hn;
                logic [6:0] dec;
                hn  = clip_h(pending_q[i]);
                dec = (peak_q[i] == 7'd0) ? 7'd0 : peak_q[i] - 7'd1;
                peak_d[i] = (hn > dec) ? hn : dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BINS; i++) peak_q[i] <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    // Pixel (0,0) is coloured in the SWAP cycle, so it uses the values being loaded.
    assign peak_src = (state_q == S_SWAP) ? peak_d[bin_sel] : peak_q[bin_sel];
    assign peak_hit = in_range && (peak_src != 7'd0) && (cnt_y_q == 7'd120 - peak_src);
`else
    assign peak_hit = 1'b0;
`endif

    // Pixel (0,0) is coloured in the SWAP cycle, so it reads the pending bank
    // that active is about to be loaded from.
    assign mag_src  = (state_q == S_SWAP) ? pending_q[bin_sel] : active_q[bin_sel];
    assign h_src    = clip_h(mag_src);
    assign in_range = cnt_x_q < PLOT_END_X;
    assign bar_hit  = in_range && (h_src != 7'd0) && (cnt_y_q >= 7'd120 - h_src);

    always_comb begin
        pix_colour = BG_COLOUR;
        if (peak_hit)     pix_colour = PEAK_COLOUR;
        else if (bar_hit) pix_colour = BAR_COLOUR;
    end

    always_comb begin
        state_d  = state_q;
        pending_d = pending_q;
        active_d = active_q;
        cnt_x_d  = cnt_x_q;
        cnt_y_d  = cnt_y_q;
        bin_d    = bin_q;
        sub_d    = sub_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        emit     = 1'b0;

        // Bin writes are accepted in every state. A write in the SWAP cycle
        // lands only in pending, because active copies the pre-edge pending.
        if (wr_ok) pending_d[bin_idx] = bin_mag;

        case (state_q)
            S_IDLE: begin
                busy_d  = 1'b0;
                cnt_x_d = '0;
                cnt_y_d = '0;
                bin_d   = '0;
                sub_d   = '0;
                if (start) begin
                    state_d = S_SWAP;
                    busy_d  = 1'b1;
                end
            end
            S_SWAP: begin
                active_d = pending_q;
                emit     = 1'b1;
                state_d  = S_SCAN;
            end
            S_SCAN: begin
                if (x_q == X_LAST && y_q == Y_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            plot_d   = 1'b1;
            x_d      = cnt_x_q;
            y_d      = cnt_y_q;
            colour_d = pix_colour;
            if (cnt_x_q == X_LAST) begin
                cnt_x_d = '0;
                cnt_y_d = cnt_y_q + 7'd1;
                bin_d   = '0;
                sub_d   = '0;
            end else begin
                cnt_x_d = cnt_x_q + 8'd1;
                if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    bin_d = bin_q + 8'd1;
                end else begin
                    sub_d = sub_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < NUM_BINS; i++) begin
                pending_q[i] <= '0;
                active_q[i]  <= '0;
            end
            cnt_x_q  <= '0;
            cnt_y_q  <= '0;
            bin_q    <= '0;
            sub_q    <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            cnt_x_q   <= cnt_x_d;
            cnt_y_q   <= cnt_y_d;
            bin_q     <= bin_d;
            sub_q     <= sub_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign plot        = plot_q;
    assign plot_x      = x_q;
    assign plot_y      = y_q;
    assign plot_colour = colour_q;
    assign dbg_state   = state_q;

endmodule
